// File: rtl/vc_out_arbiter_6to1_if.sv
// Handshake bundle between the six VC FIFOs of an output port and its VC arbiter.
// master = FIFO/mux side that drives requests, slave = the arbiter.
interface vc_out_arbiter_6to1_if #(
    parameter int CW = 4
);
    logic [5:0]    req;
    logic [5:0]    tail;
    logic          credit_in;
    logic [5:0]    mux_sel;
    logic [5:0]    pop;
    logic          flit_sent;
    logic [CW-1:0] credit_cnt;
    logic          busy;
    logic          credit_err;

    modport master (
        output req, tail, credit_in,
        input  mux_sel, pop, flit_sent, credit_cnt, busy, credit_err
    );

    modport slave (
        input  req, tail, credit_in,
        output mux_sel, pop, flit_sent, credit_cnt, busy, credit_err
    );
endinterface

// File: rtl/vc_out_arbiter_6to1.sv
// Round-robin 6-VC output arbiter with downstream credit tracking.
// Define ARB_PKT_LOCK_EN for wormhole packet lock; default is flit-level interleave.
module vc_out_arbiter_6to1 #(
    parameter int CREDITS = 4,
    parameter int CW      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    vc_out_arbiter_6to1_if.slave    io_vc
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t        r_state;
    logic [5:0]    r_mux_sel;
    logic [2:0]    r_ptr;
    logic [CW-1:0] r_credit_cnt;
    logic          r_credit_err;

    logic          w_req_g;
    logic          w_tail_g;
    logic          w_send;
    logic          w_rearb;
    logic          w_found;
    logic [2:0]    w_win;
    logic [2:0]    w_scan;
    logic [5:0]    w_win_oh;
    logic [2:0]    w_ptr_nxt;
    logic          w_cnt_full;

    assign w_req_g    = |(io_vc.req & r_mux_sel);
    assign w_tail_g   = |(io_vc.tail & r_mux_sel);
    assign w_cnt_full = (r_credit_cnt == CW'(CREDITS));
    assign w_send     = (r_state == BUSY) && w_req_g && (r_credit_cnt != '0);

`ifdef ARB_PKT_LOCK_EN
    // Grant is held across the whole packet, even if the head VC runs dry mid-packet.
    assign w_rearb = (r_state == IDLE) || (w_send && w_tail_g);
`else
    assign w_rearb = (r_state == IDLE) || w_send || !w_req_g;
`endif

    // First requester in scan order starting at r_ptr, wrapping 5 -> 0.
    always_comb begin
        w_found = 1'b0;
        w_win   = 3'd0;
        w_scan  = 3'd0;
        for (int k = 0; k < 6; k++) begin
            w_scan = 3'((int'(r_ptr) + k) % 6);
            if (!w_found && io_vc.req[w_scan]) begin
                w_found = 1'b1;
                w_win   = w_scan;
            end
        end
    end

    assign w_win_oh  = 6'b000001 << w_win;
    assign w_ptr_nxt = (w_win == 3'd5) ? 3'd0 : w_win + 3'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_mux_sel    <= '0;
            r_ptr        <= '0;
            r_credit_cnt <= CW'(CREDITS);
            r_credit_err <= 1'b0;
        end else begin
            if (w_rearb) begin
                if (w_found) begin
                    r_state   <= BUSY;
                    r_mux_sel <= w_win_oh;
                    r_ptr     <= w_ptr_nxt;
                end else begin
                    r_state   <= IDLE;
                    r_mux_sel <= '0;
                end
            end

            // A send and a returned credit in the same cycle cancel out.
            if (w_send && !io_vc.credit_in) begin
                r_credit_cnt <= r_credit_cnt - 1'b1;
            end else if (io_vc.credit_in && !w_send) begin
                if (w_cnt_full) r_credit_err <= 1'b1;
                else            r_credit_cnt <= r_credit_cnt + 1'b1;
            end
        end
    end

    assign io_vc.mux_sel    = r_mux_sel;
    assign io_vc.pop        = w_send ? r_mux_sel : 6'b0;
    assign io_vc.flit_sent  = w_send;
    assign io_vc.credit_cnt = r_credit_cnt;
    assign io_vc.busy       = (r_state == BUSY);
    assign io_vc.credit_err = r_credit_err;
endmodule

// File: tb/tb_vc_out_arbiter_6to1.sv
// Directed bench for vc_out_arbiter_6to1: vector table per cycle plus reset/error sequences.
module tb_vc_out_arbiter_6to1;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vc_out_arbiter_6to1_if #(.CW(4)) vif();

    vc_out_arbiter_6to1 #(.CREDITS(4), .CW(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .io_vc (vif)
    );

    typedef struct {
        logic [5:0] req;
        logic [5:0] tail;
        logic       cin;
        logic [5:0] mux;
        logic [5:0] pop;
        logic       fs;
        logic [3:0] cnt;
        logic       busy;
        logic       err;
    } vec_t;

    vec_t tv[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t mk(logic [5:0] req, logic [5:0] tail, logic cin, logic [5:0] mux,
                                logic [5:0] pop, logic fs, logic [3:0] cnt, logic busy, logic err);
        vec_t v;
        v.req = req; v.tail = tail; v.cin = cin; v.mux = mux; v.pop = pop;
        v.fs = fs; v.cnt = cnt; v.busy = busy; v.err = err;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input vec_t v);
        chk({nm, ".mux_sel"},    32'(vif.mux_sel),    32'(v.mux));
        chk({nm, ".pop"},        32'(vif.pop),        32'(v.pop));
        chk({nm, ".flit_sent"},  32'(vif.flit_sent),  32'(v.fs));
        chk({nm, ".credit_cnt"}, 32'(vif.credit_cnt), 32'(v.cnt));
        chk({nm, ".busy"},       32'(vif.busy),       32'(v.busy));
        chk({nm, ".credit_err"}, 32'(vif.credit_err), 32'(v.err));
    endtask

    initial begin
        bit hit;
        vif.req = '0; vif.tail = '0; vif.credit_in = 1'b0;

`ifdef ARB_PKT_LOCK_EN
        // VC2 3-flit packet vs VC4, then round robin over 100101 with all-tail flits.
        tv.push_back(mk(6'b010100, 6'b000000, 0, 6'b000000, 6'b000000, 0, 4, 0, 0));
        tv.push_back(mk(6'b010100, 6'b000000, 1, 6'b000100, 6'b000100, 1, 4, 1, 0));
        tv.push_back(mk(6'b010100, 6'b000000, 1, 6'b000100, 6'b000100, 1, 4, 1, 0));
        tv.push_back(mk(6'b010100, 6'b000100, 1, 6'b000100, 6'b000100, 1, 4, 1, 0));
        tv.push_back(mk(6'b110101, 6'b111111, 1, 6'b010000, 6'b010000, 1, 4, 1, 0));
        tv.push_back(mk(6'b100101, 6'b111111, 1, 6'b100000, 6'b100000, 1, 4, 1, 0));
        tv.push_back(mk(6'b100101, 6'b111111, 1, 6'b000001, 6'b000001, 1, 4, 1, 0));
        tv.push_back(mk(6'b100101, 6'b111111, 1, 6'b000100, 6'b000100, 1, 4, 1, 0));
        tv.push_back(mk(6'b100101, 6'b111111, 1, 6'b100000, 6'b100000, 1, 4, 1, 0));
        tv.push_back(mk(6'b100101, 6'b111111, 1, 6'b000001, 6'b000001, 1, 4, 1, 0));
        tv.push_back(mk(6'b000000, 6'b000000, 0, 6'b000100, 6'b000000, 0, 4, 1, 0));
`else
        // VC2 (3 flits) and VC4 (2 flits) interleave flit by flit.
        tv.push_back(mk(6'b010100, 6'b000000, 0, 6'b000000, 6'b000000, 0, 4, 0, 0));
        tv.push_back(mk(6'b010100, 6'b000000, 1, 6'b000100, 6'b000100, 1, 4, 1, 0));
        tv.push_back(mk(6'b010100, 6'b000000, 1, 6'b010000, 6'b010000, 1, 4, 1, 0));
        tv.push_back(mk(6'b010100, 6'b000000, 1, 6'b000100, 6'b000100, 1, 4, 1, 0));
        tv.push_back(mk(6'b010100, 6'b000000, 1, 6'b010000, 6'b010000, 1, 4, 1, 0));
        tv.push_back(mk(6'b000100, 6'b000100, 1, 6'b000100, 6'b000100, 1, 4, 1, 0));
        tv.push_back(mk(6'b000000, 6'b000000, 0, 6'b000100, 6'b000000, 0, 4, 1, 0));
        tv.push_back(mk(6'b000000, 6'b000000, 0, 6'b000000, 6'b000000, 0, 4, 0, 0));
        // VC1 6-flit packet, no credits returned: 4 pops then stall.
        tv.push_back(mk(6'b000010, 6'b000000, 0, 6'b000000, 6'b000000, 0, 4, 0, 0));
        tv.push_back(mk(6'b000010, 6'b000000, 0, 6'b000010, 6'b000010, 1, 4, 1, 0));
        tv.push_back(mk(6'b000010, 6'b000000, 0, 6'b000010, 6'b000010, 1, 3, 1, 0));
        tv.push_back(mk(6'b000010, 6'b000000, 0, 6'b000010, 6'b000010, 1, 2, 1, 0));
        tv.push_back(mk(6'b000010, 6'b000000, 0, 6'b000010, 6'b000010, 1, 1, 1, 0));
        tv.push_back(mk(6'b000010, 6'b000000, 0, 6'b000010, 6'b000000, 0, 0, 1, 0));
        tv.push_back(mk(6'b000010, 6'b000000, 1, 6'b000010, 6'b000000, 0, 0, 1, 0));
        tv.push_back(mk(6'b000010, 6'b000000, 0, 6'b000010, 6'b000010, 1, 1, 1, 0));
        tv.push_back(mk(6'b000010, 6'b000000, 1, 6'b000010, 6'b000000, 0, 0, 1, 0));
        tv.push_back(mk(6'b000010, 6'b000010, 1, 6'b000010, 6'b000010, 1, 1, 1, 0));
        tv.push_back(mk(6'b000000, 6'b000000, 1, 6'b000010, 6'b000000, 0, 1, 1, 0));
        // Send + credit at count 2, then refill to saturation and overflow.
        tv.push_back(mk(6'b001000, 6'b000000, 0, 6'b000000, 6'b000000, 0, 2, 0, 0));
        tv.push_back(mk(6'b001000, 6'b001000, 1, 6'b001000, 6'b001000, 1, 2, 1, 0));
        tv.push_back(mk(6'b000000, 6'b000000, 1, 6'b001000, 6'b000000, 0, 2, 1, 0));
        tv.push_back(mk(6'b000000, 6'b000000, 1, 6'b000000, 6'b000000, 0, 3, 0, 0));
        tv.push_back(mk(6'b000000, 6'b000000, 1, 6'b000000, 6'b000000, 0, 4, 0, 0));
        tv.push_back(mk(6'b000000, 6'b000000, 0, 6'b000000, 6'b000000, 0, 4, 0, 1));
`endif

        // Reset values while rst is held.
        #12;
        chk("rst.mux_sel",    32'(vif.mux_sel),    32'h0);
        chk("rst.busy",       32'(vif.busy),       32'h0);
        chk("rst.credit_cnt", 32'(vif.credit_cnt), 32'd4);
        chk("rst.credit_err", 32'(vif.credit_err), 32'h0);
        chk("rst.pop",        32'(vif.pop),        32'h0);
        @(negedge clk); rst = 1'b0;

        foreach (tv[i]) begin
            @(negedge clk);
            vif.req = tv[i].req; vif.tail = tv[i].tail; vif.credit_in = tv[i].cin;
            #1;
            chk_all($sformatf("v%0d", i), tv[i]);
        end

        // Overflowing credit with no send: count holds, error is sticky.
        @(negedge clk);
        vif.req = '0; vif.tail = '0; vif.credit_in = 1'b1;
        @(negedge clk);
        vif.credit_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("ovf.credit_cnt", 32'(vif.credit_cnt), 32'd4);
        chk("ovf.credit_err", 32'(vif.credit_err), 32'h1);

        // Drain credits to 1 with all VCs requesting, then reset asynchronously mid-grant.
        vif.req = 6'b111111; vif.tail = 6'b111111;
        hit = 1'b0;
        for (int c = 0; c < 12 && !hit; c++) begin
            @(negedge clk);
            if (vif.credit_cnt == 4'd1 && vif.busy) hit = 1'b1;
        end
        chk("pre_rst.reached_cnt1", 32'(hit), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("arst.mux_sel",    32'(vif.mux_sel),    32'h0);
        chk("arst.busy",       32'(vif.busy),       32'h0);
        chk("arst.credit_cnt", 32'(vif.credit_cnt), 32'd4);
        chk("arst.credit_err", 32'(vif.credit_err), 32'h0);
        chk("arst.pop",        32'(vif.pop),        32'h0);
        chk("arst.flit_sent",  32'(vif.flit_sent),  32'h0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        chk("post_rst.mux_sel", 32'(vif.mux_sel), 32'h01);
        chk("post_rst.pop",     32'(vif.pop),     32'h01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/vc_out_arbiter_6to1.md
# vc_out_arbiter_6to1

Round-robin output-port arbiter for the six virtual channels of one router output. It generates the one-hot select for the 6-to-1 VC data/valid multiplexer and dequeue strobes back to the VC buffers. It also tracks downstream buffer credits so a flit is forwarded only when the next hop can accept it. One instance sits between the six input VC FIFOs of an output port and that port's VC mux.

## Interface
- CREDITS, 4: downstream buffer depth in flits. Credit counter reset value. Range 1..15.
- CW, 4: credit counter width. Must satisfy 2^CW > CREDITS.

- clk  in  1  system clock, rising-edge
- rst  in  1  asynchronous, active-high reset
- req  in  6  req[i]=1: VC i holds at least one flit at its head
- tail  in  6  tail[i]=1: head flit of VC i is a packet tail. Qualified by req[i].
- credit_in  in  1  one-cycle pulse: downstream freed one slot
- mux_sel  out  6  one-hot VC select to the data/valid mux, registered; 6'b0 when idle
- pop  out  6  combinational dequeue strobe; pop = mux_sel when send, else 0
- flit_sent  out  1  combinational; send condition this cycle
- credit_cnt  out  CW  current credit count, registered
- busy  out  1  registered; 1 when mux_sel != 0
- credit_err  out  1  sticky; credit_in received with credit_cnt == CREDITS

## Operation
- States: IDLE (mux_sel=0) and BUSY (mux_sel one-hot, granted VC g).
- Send condition: send = busy & req[g] & (credit_cnt != 0).
- On each send, pop[g] and flit_sent assert for that cycle.
- Round-robin pointer ptr (3 bits, 0..5): the highest-priority VC. Scan order is ptr, ptr+1, … wrapping 5→0.
- On each grant to VC w, ptr ← (w+1) mod 6.
- Arbitration evaluates req against ptr; the winner is the first VC in scan order with req=1.
- Re-arbitration points:
  - IDLE with req != 0.
  - BUSY on a send of the last flit of the grant (see Configuration).
  - BUSY with req[g]=0, only when the macro is undefined.
- At a re-arbitration point with req != 0:
  - mux_sel ← onehot(winner), next state BUSY. No bubble between back-to-back grants.
  - The just-served VC may win again only if no other VC requests; the pointer already deprioritises it.
- At a re-arbitration point with req == 0: mux_sel ← 0, next state IDLE.
- Credits (width CW):
  - send without credit_in: decrement.
  - credit_in without send: increment, saturating at CREDITS. At saturation, set credit_err and leave the count unchanged.
  - send and credit_in together: count unchanged.
- When credit_cnt == 0 in BUSY: hold the grant, mux_sel stays, no pop. This holds even when the macro is undefined, provided req[g]=1.

## Timing
- Reset values: mux_sel=0, busy=0, credit_cnt=CREDITS, ptr=0, credit_err=0. pop and flit_sent are 0 because busy=0.
- Reset is asserted asynchronously. An in-flight grant is dropped. A partially sent packet is not resumed by this block; upstream buffers are reset on the same rst.
- Latency:
  - req rising in IDLE at edge N produces mux_sel valid after edge N, i.e. in cycle N+1.
  - The first pop is in cycle N+1 if credits are available.
- Steady state: one flit per cycle while req[g]=1 and credits > 0.
- A VC buffer must deassert req[i] in the cycle after its last flit is popped. The arbiter samples req combinationally for send.

## Configuration
- ARB_PKT_LOCK_EN defined (wormhole lock):
  - The grant is held from the first flit until a send with tail[g]=1. That send is the re-arbitration point.
  - If req[g] drops mid-packet, the grant is held and the arbiter waits.
- ARB_PKT_LOCK_EN undefined (flit-level interleave):
  - Every send is a re-arbitration point.
  - Also re-arbitrates whenever req[g]=0 in BUSY.
  - tail is ignored.

## Test plan
- Reset: assert rst mid-BUSY with credit_cnt=1 → immediately mux_sel=0, busy=0, credit_cnt=4, and after release the first grant goes to VC0 when req=6'b111111.
- Round-robin with the macro defined: req=6'b100101, every flit a tail, credits replenished each cycle → mux_sel sequence 000001, 000100, 100000, 000001, one pop per cycle, no idle cycles.
- Packet lock with the macro defined:
  - VC2 sends 3-flit packet (tail on 3rd) while VC4 requests → mux_sel=000100 for exactly 3 sends, then 010000.
  - Macro undefined, same stimulus → 000100, 010000, 000100, 010000, 000100 (interleaved sends).
- Credit stall: CREDITS=4, VC1 sends 6-flit packet with no credit_in → 4 pops, credit_cnt=0, mux_sel held at 000010, pop=0. A single credit_in pulse → exactly one further pop.
- Simultaneous send and credit_in at credit_cnt=2 → count stays 2. credit_in at credit_cnt=4 with no send → credit_cnt stays 4, credit_err=1 and remains set until rst.
